// File: rtl/sliced_add_sequencer_pkg.sv
// Shared definitions for the sliced adder sequencer: slice width, FSM states
// and the slice-index width helper.
package sliced_add_sequencer_pkg;

  localparam int SLICE_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int idx_w(input int nslice);
    return (nslice > 1) ? $clog2(nslice) : 1;
  endfunction

endpackage

// File: rtl/sliced_add_sequencer_cla.sv
// Five-bit carry-lookahead adder with carry-in; the single slice adder that the
// sequencer time-shares across all operand slices.
module alt_carry_look_ahead_adder_cin_5 (
  input  logic [4:0] a_i,
  input  logic [4:0] b_i,
  input  logic       cin_i,
  output logic [4:0] sum_o,
  output logic       cout_o
);

  logic [4:0] g;
  logic [4:0] p;
  logic [5:0] c;

  assign g = a_i & b_i;
  assign p = a_i ^ b_i;

  // Every carry is flattened to generate/propagate terms of the slice inputs.
  assign c[0] = cin_i;
  assign c[1] = g[0] | (p[0] & cin_i);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin_i);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin_i);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin_i);
  assign c[5] = g[4] | (p[4] & g[3]) | (p[4] & p[3] & g[2])
              | (p[4] & p[3] & p[2] & g[1])
              | (p[4] & p[3] & p[2] & p[1] & g[0])
              | (p[4] & p[3] & p[2] & p[1] & p[0] & cin_i);

  assign sum_o  = p ^ c[4:0];
  assign cout_o = c[5];

endmodule

// File: rtl/sliced_add_sequencer.sv
// Multi-cycle W-bit adder: one 5-bit CLA slice processes one operand slice per
// cycle. Define SLICED_ADD_SUB_EN to add the 'sub' port (adds ~B instead of B).
module sliced_add_sequencer
  import sliced_add_sequencer_pkg::*;
#(
  parameter int NSLICE = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [SLICE_W*NSLICE-1:0] A,
  input  logic [SLICE_W*NSLICE-1:0] B,
  input  logic                      cin,
`ifdef SLICED_ADD_SUB_EN
  input  logic                      sub,
`endif
  output logic                      busy,
  output logic                      done,
  output logic [SLICE_W*NSLICE-1:0] R,
  output logic                      cout,
  output logic                      ovf
);

  localparam int W  = SLICE_W * NSLICE;
  localparam int KW = idx_w(NSLICE);
  localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

  state_e       state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;
  logic         c_q, c_d;
  logic [W-1:0] r_q, r_d;
  logic         cout_q, cout_d;
  logic         ovf_q, ovf_d;
  logic         done_q;

  logic [W-1:0]         b_in;
  logic [SLICE_W-1:0]   s_a, s_b, s_sum;
  logic                 s_cout;

`ifdef SLICED_ADD_SUB_EN
  assign b_in = sub ? ~B : B;
`else
  assign b_in = B;
`endif

  assign s_a = a_q[k_q*SLICE_W +: SLICE_W];
  assign s_b = b_q[k_q*SLICE_W +: SLICE_W];

  alt_carry_look_ahead_adder_cin_5 u_slice (
    .a_i    (s_a),
    .b_i    (s_b),
    .cin_i  (c_q),
    .sum_o  (s_sum),
    .cout_o (s_cout)
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    r_d     = r_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = A;
          b_d     = b_in;
          c_d     = cin;
          k_d     = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        r_d[k_q*SLICE_W +: SLICE_W] = s_sum;
        c_d = s_cout;
        k_d = k_q + 1'b1;
        if (k_q == K_LAST) begin
          k_d     = '0;
          cout_d  = s_cout;
          // The top slice's sum bit is the new sign of R.
          ovf_d   = (a_q[W-1] == b_q[W-1]) && (s_sum[SLICE_W-1] != a_q[W-1]);
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      r_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      r_q     <= r_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      // Registered DONE marker: pulse lands one cycle after DONE is entered.
      done_q  <= (state_q == DONE);
    end
  end

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign R    = r_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule
